// File: rtl/nibble_serializer.sv
// nibble_serializer: takes a DATA_WIDTH word over valid/ready and
// emits it one registered nibble per transfer, MSB- or LSB-first.
//
// Ports:
//   i_Clk, i_Rst_L         clock, synchronous active-low reset
//   i_Data, i_Valid        word input
//   o_Ready                word accepted when i_Valid & o_Ready
//   o_Nibble, o_Index      current nibble and its index in the word
//   o_Last                 current nibble is the final one
//   o_Nibble_Valid         nibble valid
//   i_Nibble_Ready         nibble accepted when valid & ready
module nibble_serializer #(
  parameter int DATA_WIDTH  = 12,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit SUPPRESS_LZ = 1'b0,
  localparam int N  = DATA_WIDTH / 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  output logic [3:0]            o_Nibble,
  output logic                  o_Nibble_Valid,
  input  logic                  i_Nibble_Ready,
  output logic                  o_Last,
  output logic [IW-1:0]         o_Index
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         end_q, end_d;
  logic [3:0]            nib_q, nib_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;

  logic [IW-1:0] hi_idx;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] first_idx;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] step_idx;

  function automatic logic [3:0] nib_at(
    input logic [DATA_WIDTH-1:0] w,
    input logic [IW-1:0]         k
  );
    logic [DATA_WIDTH-1:0] s;
    s = w >> {k, 2'b00};
    return s[3:0];
  endfunction

  // Highest nonzero nibble of the incoming word; 0 for an
  // all-zero word so one nibble is always emitted.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_Data[i*4 +: 4] != 4'd0) begin
        hi_idx = IW'(i);
      end
    end
  end

  always_comb begin
    top_idx   = SUPPRESS_LZ ? hi_idx : IW'(N - 1);
    first_idx = MSB_FIRST ? top_idx : '0;
    last_idx  = MSB_FIRST ? '0 : top_idx;
  end

  // Never wraps: stepping only happens while not on the last index.
  assign step_idx = MSB_FIRST ? (idx_q - IW'(1))
                              : (idx_q + IW'(1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      end_q   <= '0;
      nib_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      nib_q   <= nib_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    end_d   = end_q;
    nib_d   = nib_q;
    last_d  = last_q;
    valid_d = valid_q;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: begin
        if (i_Valid) begin
          state_d = SEND;
          word_d  = i_Data;
          idx_d   = first_idx;
          end_d   = last_idx;
          nib_d   = nib_at(i_Data, first_idx);
          last_d  = (first_idx == last_idx);
          valid_d = 1'b1;
          ready_d = 1'b0;
        end
      end
      SEND: begin
        if (i_Nibble_Ready) begin
          if (last_q) begin
            state_d = IDLE;
            idx_d   = '0;
            nib_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            idx_d  = step_idx;
            nib_d  = nib_at(word_q, step_idx);
            last_d = (step_idx == end_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign o_Ready        = ready_q;
  assign o_Nibble       = nib_q;
  assign o_Nibble_Valid = valid_q;
  assign o_Last         = last_q;
  assign o_Index        = idx_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: three configurations of nibble_serializer
// sharing stimulus, checked against per-instance expected queues.
module tb_nibble_serializer;

  logic        clk;
  logic        rst_n;
  logic [11:0] data;
  logic        valid;
  logic        nready;

  logic       rdy  [3];
  logic [3:0] nib  [3];
  logic       nv   [3];
  logic       last [3];
  logic [1:0] idx  [3];

  logic [6:0] sbq [3][$];
  int         xfers [3];
  int         accs  [3];
  int         checks;
  int         passes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: MSB-first, 1: LSB-first, 2: MSB-first with zero suppression
  nibble_serializer #(
    .DATA_WIDTH(12), .MSB_FIRST(1'b1), .SUPPRESS_LZ(1'b0)
  ) u_msb (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data(data), .i_Valid(valid),
    .o_Ready(rdy[0]), .o_Nibble(nib[0]),
    .o_Nibble_Valid(nv[0]), .i_Nibble_Ready(nready),
    .o_Last(last[0]), .o_Index(idx[0])
  );

  nibble_serializer #(
    .DATA_WIDTH(12), .MSB_FIRST(1'b0), .SUPPRESS_LZ(1'b0)
  ) u_lsb (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data(data), .i_Valid(valid),
    .o_Ready(rdy[1]), .o_Nibble(nib[1]),
    .o_Nibble_Valid(nv[1]), .i_Nibble_Ready(nready),
    .o_Last(last[1]), .o_Index(idx[1])
  );

  nibble_serializer #(
    .DATA_WIDTH(12), .MSB_FIRST(1'b1), .SUPPRESS_LZ(1'b1)
  ) u_lz (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Data(data), .i_Valid(valid),
    .o_Ready(rdy[2]), .o_Nibble(nib[2]),
    .o_Nibble_Valid(nv[2]), .i_Nibble_Ready(nready),
    .o_Last(last[2]), .o_Index(idx[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected sequence entry: {last, index, nibble}
  task automatic push_word(input int i, input logic [11:0] w);
    bit msb;
    bit lz;
    int h;
    int top;
    logic [3:0] n;
    msb = (i != 1);
    lz  = (i == 2);
    h = 0;
    for (int k = 0; k < 3; k++) begin
      n = w[k*4 +: 4];
      if (n != 4'd0) h = k;
    end
    top = lz ? h : 2;
    if (msb) begin
      for (int k = top; k >= 0; k--) begin
        n = w[k*4 +: 4];
        sbq[i].push_back({k == 0, 2'(k), n});
      end
    end else begin
      for (int k = 0; k <= top; k++) begin
        n = w[k*4 +: 4];
        sbq[i].push_back({k == top, 2'(k), n});
      end
    end
  endtask

  // Evaluates the handshakes about to happen on the next edge,
  // then advances one cycle.
  task automatic cyc();
    logic [6:0] e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        sbq[i].delete();
      end else begin
        if (nv[i] && nready) begin
          xfers[i]++;
          if (sbq[i].size() == 0) begin
            chk($sformatf("unexpected nibble inst%0d", i),
                {last[i], idx[i], nib[i]}, 32'h7f);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("nibble inst%0d", i), nib[i], e[3:0]);
            chk($sformatf("index inst%0d", i), idx[i], e[5:4]);
            chk($sformatf("last inst%0d", i), last[i], e[6]);
          end
        end
        if (valid && rdy[i]) begin
          accs[i]++;
          push_word(i, data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 3; i++) begin
      xfers[i] = 0;
      accs[i]  = 0;
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && k < 50) begin
      cyc();
      k++;
    end
    chk("ready timeout", rdy[0] && rdy[1] && rdy[2], 1);
  endtask

  task automatic send(input logic [11:0] w);
    wait_ready();
    clr_counts();
    data  = w;
    valid = 1'b1;
    cyc();
    valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    bit busy;
    k = 0;
    busy = 1'b1;
    while (busy && k < 100) begin
      busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (sbq[i].size() != 0 || nv[i]) busy = 1'b1;
      end
      if (busy) begin
        cyc();
        k++;
      end
    end
    chk("drain timeout", busy, 0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    clr_counts();
    rst_n  = 1'b0;
    valid  = 1'b0;
    data   = '0;
    nready = 1'b1;
    @(posedge clk);
    #1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ready%0d", i), rdy[i], 1);
      chk($sformatf("reset valid%0d", i), nv[i], 0);
      chk($sformatf("reset nibble%0d", i), nib[i], 0);
      chk($sformatf("reset last%0d", i), last[i], 0);
      chk($sformatf("reset index%0d", i), idx[i], 0);
    end
    rst_n = 1'b1;
    cyc();

    // Latency and order for CDF, continuous ready
    send(12'hCDF);
    chk("t1 valid t+1", nv[0], 1);
    chk("t1 nib t+1", nib[0], 4'hC);
    chk("t1 lsb nib t+1", nib[1], 4'hF);
    chk("t1 ready t+1", rdy[0], 0);
    cyc();
    cyc();
    chk("t1 nib t+3", nib[0], 4'hF);
    chk("t1 last t+3", last[0], 1);
    chk("t1 lsb last t+3", last[1], 1);
    cyc();
    chk("t1 ready t+4", rdy[0], 1);
    chk("t1 valid t+4", nv[0], 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1 xfers%0d", i), xfers[i], 3);
      chk($sformatf("t1 queue%0d", i), sbq[i].size(), 0);
    end

    // Leading-zero suppression
    send(12'h00A);
    chk("lz 00A nib", nib[2], 4'hA);
    chk("lz 00A idx", idx[2], 0);
    chk("lz 00A last", last[2], 1);
    chk("msb 00A nib", nib[0], 4'h0);
    drain();
    chk("lz 00A xfers", xfers[2], 1);
    chk("msb 00A xfers", xfers[0], 3);
    send(12'h000);
    chk("lz 000 last", last[2], 1);
    drain();
    chk("lz 000 xfers", xfers[2], 1);
    send(12'h05A);
    chk("lz 05A first", nib[2], 4'h5);
    drain();
    chk("lz 05A xfers", xfers[2], 2);

    // Backpressure on D
    send(12'hCDF);
    cyc();
    nready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp hold nib", nib[0], 4'hD);
      chk("bp hold idx", idx[0], 1);
      chk("bp hold valid", nv[0], 1);
      cyc();
    end
    nready = 1'b1;
    drain();
    chk("bp xfers", xfers[0], 3);

    // Reset mid-word
    send(12'hCDF);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid rst valid%0d", i), nv[i], 0);
      chk($sformatf("mid rst ready%0d", i), rdy[i], 1);
      chk($sformatf("mid rst nib%0d", i), nib[i], 0);
      chk($sformatf("mid rst idx%0d", i), idx[i], 0);
      chk($sformatf("mid rst last%0d", i), last[i], 0);
    end
    send(12'h123);
    drain();
    chk("post rst xfers", xfers[0], 3);

    // Busy-ignore: i_Valid held with a new word during SEND
    wait_ready();
    clr_counts();
    data  = 12'hCDF;
    valid = 1'b1;
    cyc();
    data = 12'h456;
    for (int k = 0; k < 3; k++) begin
      chk("busy ready low", rdy[0], 0);
      cyc();
    end
    chk("busy ready back", rdy[0], 1);
    chk("busy accepts", accs[0], 1);
    cyc();
    valid = 1'b0;
    chk("busy new word", nib[0], 4'h4);
    chk("busy accepts 2", accs[0], 2);
    drain();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy xfers%0d", i), xfers[i], 6);
      chk($sformatf("end queue%0d", i), sbq[i].size(), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
